decode_cycle: RTL and testbench
===============================

// Module: decode_cycle
// PURPOSE
//   RV32I decode stage; sits directly downstream of fetch_cycle and consumes its IF/ID outputs.
//   Decodes instruction, reads 32x32 register file (written back from W), sign-extends immediate.
//   Registers all results into the ID/EX pipeline register for the execute stage.
//   Supports R-type ALU, I-type ALU, lw, sw, beq, jal; every other opcode decodes as a bubble.
// PARAMETERS
//   XLEN    32  datapath / register width
//   NREGS   32  architectural registers; x0 hardwired to zero
// PORTS
//   clk           in   1     clock; all state updates on rising edge
//   rst           in   1     asynchronous, active-high reset
//   InstrD        in   32    instruction from IF/ID
//   PCD           in   32    PC of InstrD
//   PCPlus4D      in   32    PCD+4
//   FlushE        in   1     load bubble into ID/EX this cycle
//   RegWriteW     in   1     writeback enable
//   RdW           in   5     writeback destination
//   ResultW       in   32    writeback data
//   RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE   out 1 each   registered control
//   ResultSrcE    out  2     00 ALU, 01 memory, 10 PC+4
//   ALUControlE   out  3     000 add, 001 sub, 010 and, 011 or, 101 slt
//   RD1E, RD2E    out  32    register operands
//   ImmExtE       out  32    sign-extended immediate
//   Rs1E, Rs2E, RdE  out 5   register indices (for hazard unit)
//   PCE, PCPlus4E out  32    forwarded PC values
// BEHAVIOUR
//   Reset: rst high -> every E output 0 and all registers 0, immediately (async); held while high.
//   Latency: one cycle; values decoded from InstrD in cycle n appear on E outputs after edge n+1.
//   Register file: write on rising edge when RegWriteW=1 and RdW!=0; writes to x0 ignored.
//   Read bypass: if RegWriteW=1, RdW!=0 and RdW==rs1/rs2, the read returns ResultW (same cycle).
//   Reads of x0 always return 0.
//   Fields: rs1=[19:15], rs2=[24:20], rd=[11:7], op=[6:0], f3=[14:12], f7b5=[30].
//   Main decode (op -> RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,Branch,ALUOp,Jump):
//     0000011 lw  1,I,1,0,01,0,00,0 | 0100011 sw 0,S,1,1,00,0,00,0
//     0110011 R   1,-,0,0,00,0,10,0 | 1100011 beq 0,B,0,0,00,1,01,0
//     0010011 I   1,I,1,0,00,0,10,0 | 1101111 jal 1,J,0,0,10,0,00,1
//     other: all controls 0 (bubble); RD/Imm/PC fields still registered.
//   ALU decode: ALUOp 00->add, 01->sub; ALUOp 10: f3 000 -> sub if op[5]&f7b5 else add,
//     010 slt, 110 or, 111 and, other f3 -> add.
//   Immediate: I={{20{i[31]}},i[31:20]}; S={{20{i[31]}},i[31:25],i[11:7]};
//     B={{20{i[31]}},i[7],i[30:25],i[11:8],1'b0}; J={{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}.
//   FlushE=1 at edge: all control outputs (RegWriteE..ALUControlE) and Rs1E/Rs2E/RdE load 0;
//     data outputs may load any value. Register-file write in the same cycle still happens.
//   Reset mid-operation: pending writeback is dropped; register file returns to all-zero.
// TESTING
//   Reset: assert rst mid-run -> all E outputs 0 without a clock edge; x5 reads 0 afterwards.
//   Writeback+bypass: RegWriteW=1,RdW=5,ResultW=0xDEADBEEF, InstrD=add x1,x5,x0 (0x000280B3)
//     -> next edge RD1E=0xDEADBEEF, ALUControlE=000, RegWriteE=1, RdE=1.
//   x0 guard: RegWriteW=1,RdW=0,ResultW=0x1234 then read x0 -> RD1E=0.
//   Immediates: lw x2,-4(x3) (0xFFC1A103) -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1;
//     beq x0,x0,-8 (0xFE000CE3) -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
//   jal x1,+16 (0x010000EF), PCD=0x100, PCPlus4D=0x104 -> JumpE=1, ResultSrcE=10,
//     ImmExtE=0x10, PCE=0x100, PCPlus4E=0x104.
//   Flush/illegal: FlushE=1 with valid sub -> controls 0; InstrD=0xFFFFFFFF -> controls 0.

Source files
------------

// File: rtl/decode_cycle_if.sv
// IF/ID, writeback and ID/EX signal bundle for the RV32I decode stage.
// The slave side is the decode stage; the master side drives it and consumes the E outputs.
interface decode_cycle_if #(
  parameter int unsigned XLEN = 32
);
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            FlushE;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;

  logic            RegWriteE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RdW, ResultW,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register file with writeback bypass,
// immediate extension and the ID/EX pipeline register.
module decode_cycle #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input logic           clk,
  input logic           rst,
  decode_cycle_if.slave bus
);
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101
  } alu_ctrl_e;
  typedef enum logic [6:0] {
    OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
    OP_BEQ = 7'b1100011, OP_I = 7'b0010011, OP_JAL = 7'b1101111
  } opcode_e;

  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7b5;
  logic [4:0]  rs1, rs2, rd;

  assign instr = bus.InstrD;
  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign f7b5  = instr[30];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign rd    = instr[11:7];

  logic       reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0] result_src_d;
  imm_src_e   imm_src;
  alu_op_e    alu_op;
  alu_ctrl_e  alu_ctrl_d;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    result_src_d = 2'b00;
    imm_src      = IMM_I;
    alu_op       = ALUOP_ADD;
    case (op)
      OP_LW:  begin reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 2'b01; end
      OP_SW:  begin mem_write_d = 1'b1; alu_src_d = 1'b1; imm_src = IMM_S; end
      OP_R:   begin reg_write_d = 1'b1; alu_op = ALUOP_FUNCT; end
      OP_BEQ: begin branch_d = 1'b1; imm_src = IMM_B; alu_op = ALUOP_SUB; end
      OP_I:   begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op = ALUOP_FUNCT; end
      OP_JAL: begin reg_write_d = 1'b1; jump_d = 1'b1; result_src_d = 2'b10; imm_src = IMM_J; end
      default: ;
    endcase
  end

  always_comb begin
    alu_ctrl_d = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl_d = ALU_SUB;
      ALUOP_FUNCT: begin
        case (f3)
          3'b000:  alu_ctrl_d = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_d = ALU_SLT;
          3'b110:  alu_ctrl_d = ALU_OR;
          3'b111:  alu_ctrl_d = ALU_AND;
          default: alu_ctrl_d = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] imm_ext;

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm_ext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_ext = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm_ext = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  logic [XLEN-1:0] rf_q [NREGS];
  logic            wb_en;
  logic [XLEN-1:0] rd1, rd2;

  assign wb_en = bus.RegWriteW && (bus.RdW != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[bus.RdW] <= bus.ResultW;
    end
  end

  // Writeback in the same cycle is visible to the read (register file written late in W).
  always_comb begin
    rd1 = (wb_en && bus.RdW == rs1) ? bus.ResultW : rf_q[rs1];
    rd2 = (wb_en && bus.RdW == rs2) ? bus.ResultW : rf_q[rs2];
    if (rs1 == '0) rd1 = '0;
    if (rs2 == '0) rd2 = '0;
  end

  logic            reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
  logic [1:0]      result_src_q;
  logic [2:0]      alu_ctrl_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      result_src_q <= '0;
      alu_ctrl_q   <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      pc_plus4_q   <= '0;
    end else begin
      if (bus.FlushE) begin
        reg_write_q  <= 1'b0;
        mem_write_q  <= 1'b0;
        jump_q       <= 1'b0;
        branch_q     <= 1'b0;
        alu_src_q    <= 1'b0;
        result_src_q <= '0;
        alu_ctrl_q   <= '0;
        rs1_q        <= '0;
        rs2_q        <= '0;
        rd_q         <= '0;
      end else begin
        reg_write_q  <= reg_write_d;
        mem_write_q  <= mem_write_d;
        jump_q       <= jump_d;
        branch_q     <= branch_d;
        alu_src_q    <= alu_src_d;
        result_src_q <= result_src_d;
        alu_ctrl_q   <= alu_ctrl_d;
        rs1_q        <= rs1;
        rs2_q        <= rs2;
        rd_q         <= rd;
      end
      rd1_q      <= rd1;
      rd2_q      <= rd2;
      imm_q      <= imm_ext;
      pc_q       <= bus.PCD;
      pc_plus4_q <= bus.PCPlus4D;
    end
  end

  assign bus.RegWriteE   = reg_write_q;
  assign bus.MemWriteE   = mem_write_q;
  assign bus.JumpE       = jump_q;
  assign bus.BranchE     = branch_q;
  assign bus.ALUSrcE     = alu_src_q;
  assign bus.ResultSrcE  = result_src_q;
  assign bus.ALUControlE = alu_ctrl_q;
  assign bus.Rs1E        = rs1_q;
  assign bus.Rs2E        = rs2_q;
  assign bus.RdE         = rd_q;
  assign bus.RD1E        = rd1_q;
  assign bus.RD2E        = rd2_q;
  assign bus.ImmExtE     = imm_q;
  assign bus.PCE         = pc_q;
  assign bus.PCPlus4E    = pc_plus4_q;
endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: one task per scenario with hand-computed expectations.
module tb_decode_cycle;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  decode_cycle_if #(.XLEN(32)) dif ();

  decode_cycle #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  // {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}
  logic [9:0]   ctrl;
  logic [217:0] all_out;
  assign ctrl    = {dif.RegWriteE, dif.MemWriteE, dif.JumpE, dif.BranchE, dif.ALUSrcE,
                    dif.ResultSrcE, dif.ALUControlE};
  assign all_out = {ctrl, dif.RD1E, dif.RD2E, dif.ImmExtE, dif.Rs1E, dif.Rs2E, dif.RdE,
                    dif.PCE, dif.PCPlus4E};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic flush, input logic wen,
                       input logic [4:0] rdw, input logic [31:0] res);
    dif.InstrD    = instr;
    dif.FlushE    = flush;
    dif.RegWriteW = wen;
    dif.RdW       = rdw;
    dif.ResultW   = res;
  endtask

  task automatic test_reset();
    drive(32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    dif.PCD = 32'h0;
    dif.PCPlus4D = 32'h0;
    #1 rst = 1'b1;
    #2;
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_writeback_bypass();
    drive(32'h000280B3, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    total++;
    if (dif.RD1E !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_rd1: got %h want deadbeef", dif.RD1E); end
    total++;
    if (dif.ALUControlE !== 3'b000) begin bad++; $display("FAIL bypass_aluctl: got %b want 000", dif.ALUControlE); end
    total++;
    if (dif.RegWriteE !== 1'b1) begin bad++; $display("FAIL bypass_regwrite: got %b want 1", dif.RegWriteE); end
    total++;
    if (dif.RdE !== 5'd1) begin bad++; $display("FAIL bypass_rd: got %0d want 1", dif.RdE); end
    total++;
    if (dif.Rs1E !== 5'd5 || dif.RD2E !== 32'h0) begin
      bad++; $display("FAIL bypass_rs1_rd2: got rs1=%0d rd2=%h want 5,0", dif.Rs1E, dif.RD2E);
    end
    drive(32'h005000B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    total++;
    if (dif.RD2E !== 32'hDEADBEEF || dif.RD1E !== 32'h0) begin
      bad++; $display("FAIL regfile_read_x5: got rd1=%h rd2=%h want 0,deadbeef", dif.RD1E, dif.RD2E);
    end
  endtask

  task automatic test_x0_guard();
    drive(32'h000000B3, 1'b0, 1'b1, 5'd0, 32'h00001234);
    tick();
    total++;
    if (dif.RD1E !== 32'h0) begin bad++; $display("FAIL x0_bypass: got %h want 0", dif.RD1E); end
    drive(32'h000000B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    total++;
    if (dif.RD1E !== 32'h0 || dif.RD2E !== 32'h0) begin
      bad++; $display("FAIL x0_stored: got rd1=%h rd2=%h want 0,0", dif.RD1E, dif.RD2E);
    end
  endtask

  task automatic test_alu_decode();
    logic [31:0] instrs [6];
    logic [2:0]  exp_ctl [6];
    instrs = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3, 32'h0020C1B3, 32'h40008193};
    exp_ctl = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b000, 3'b000};
    for (int i = 0; i < 6; i++) begin
      drive(instrs[i], 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      total++;
      if (dif.ALUControlE !== exp_ctl[i]) begin
        bad++; $display("FAIL alu_decode[%0d]: got %b want %b", i, dif.ALUControlE, exp_ctl[i]);
      end
    end
    total++;
    if (dif.ImmExtE !== 32'h00000400 || dif.ALUSrcE !== 1'b1) begin
      bad++; $display("FAIL addi_imm: got imm=%h alusrc=%b want 00000400,1", dif.ImmExtE, dif.ALUSrcE);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] instrs [3];
    logic [31:0] exp_imm [3];
    logic [9:0]  exp_ctrl [3];
    instrs   = '{32'hFFC1A103, 32'hFE512E23, 32'hFE000CE3};
    exp_imm  = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFF8};
    exp_ctrl = '{10'b1000101000, 10'b0100100000, 10'b0001000001};
    for (int i = 0; i < 3; i++) begin
      drive(instrs[i], 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      total++;
      if (dif.ImmExtE !== exp_imm[i]) begin
        bad++; $display("FAIL imm[%0d]: got %h want %h", i, dif.ImmExtE, exp_imm[i]);
      end
      total++;
      if (ctrl !== exp_ctrl[i]) begin
        bad++; $display("FAIL ctrl[%0d]: got %b want %b", i, ctrl, exp_ctrl[i]);
      end
    end
  endtask

  task automatic test_jal();
    drive(32'h010000EF, 1'b0, 1'b0, 5'd0, 32'h0);
    dif.PCD = 32'h100;
    dif.PCPlus4D = 32'h104;
    tick();
    total++;
    if (dif.JumpE !== 1'b1 || dif.ResultSrcE !== 2'b10) begin
      bad++; $display("FAIL jal_ctrl: got jump=%b rsrc=%b want 1,10", dif.JumpE, dif.ResultSrcE);
    end
    total++;
    if (dif.ImmExtE !== 32'h10) begin bad++; $display("FAIL jal_imm: got %h want 00000010", dif.ImmExtE); end
    total++;
    if (dif.PCE !== 32'h100 || dif.PCPlus4E !== 32'h104) begin
      bad++; $display("FAIL jal_pc: got pc=%h pc4=%h want 100,104", dif.PCE, dif.PCPlus4E);
    end
    total++;
    if (ctrl !== 10'b1010010000 || dif.RdE !== 5'd1) begin
      bad++; $display("FAIL jal_all: got ctrl=%b rd=%0d want 1010010000,1", ctrl, dif.RdE);
    end
    dif.PCD = 32'h0;
    dif.PCPlus4D = 32'h0;
  endtask

  task automatic test_flush_illegal();
    drive(32'h402081B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    total++;
    if (ctrl !== 10'b1000000001) begin bad++; $display("FAIL pre_flush_sub: got %b want 1000000001", ctrl); end
    drive(32'h402081B3, 1'b1, 1'b1, 5'd7, 32'hCAFEF00D);
    tick();
    total++;
    if (ctrl !== 10'b0) begin bad++; $display("FAIL flush_ctrl: got %b want 0", ctrl); end
    total++;
    if ({dif.Rs1E, dif.Rs2E, dif.RdE} !== 15'b0) begin
      bad++; $display("FAIL flush_regs: got %0d %0d %0d want 0 0 0", dif.Rs1E, dif.Rs2E, dif.RdE);
    end
    drive(32'h000380B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    total++;
    if (dif.RD1E !== 32'hCAFEF00D || ctrl !== 10'b1000000000) begin
      bad++; $display("FAIL flush_wb_kept: got rd1=%h ctrl=%b want cafef00d,1000000000", dif.RD1E, ctrl);
    end
    drive(32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    total++;
    if (ctrl !== 10'b0) begin bad++; $display("FAIL illegal_ctrl: got %b want 0", ctrl); end
  endtask

  task automatic test_reset_midrun();
    drive(32'h000280B3, 1'b0, 1'b1, 5'd5, 32'h00000055);
    dif.PCD = 32'h200;
    dif.PCPlus4D = 32'h204;
    tick();
    total++;
    if (dif.RD1E !== 32'h55) begin bad++; $display("FAIL pre_reset_rd1: got %h want 00000055", dif.RD1E); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", all_out); end
    tick();
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_held: got %h want 0", all_out); end
    rst = 1'b0;
    drive(32'h000280B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    total++;
    if (dif.RD1E !== 32'h0) begin bad++; $display("FAIL x5_after_reset: got %h want 0", dif.RD1E); end
    drive(32'h000380B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    total++;
    if (dif.RD1E !== 32'h0) begin bad++; $display("FAIL x7_after_reset: got %h want 0", dif.RD1E); end
  endtask

  initial begin
    test_reset();
    test_writeback_bypass();
    test_x0_guard();
    test_alu_decode();
    test_immediates();
    test_jal();
    test_flush_illegal();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
